complex_result_accumulator: RTL and testbench
=============================================

Name: complex_result_accumulator

Overview:
- Consumer on the result side of the complex number multiplier: terminates the res_val/res_ready/res_data handshake as the downstream receiver.
- Accumulates ACC_LEN consecutive complex products into a complex sum, then presents the sum on an output valid/ready handshake.
- Sits between the complex multiplier and the next processing stage. Together the two blocks form a complex multiply-accumulate (dot-product) datapath.

Parameters:
- DATA_WIDTH, 8, operand width of the multiplier. Each result part is 2*DATA_WIDTH bits signed.
- ACC_LEN, 4, number of results summed per output. Legal range 2..255.
- GUARD_BITS, 4, extra accumulator MSBs. Must be >= ceil(log2(ACC_LEN)).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset.
- sw_rst  input  1  synchronous active-high soft reset, same effect as rstn.
- res_val  input  1  multiplier result valid.
- res_ready  output  1  accumulator can accept a result.
- res_data  input  4*DATA_WIDTH  [4*DW-1:2*DW] = real part, [2*DW-1:0] = imaginary part. Both signed two's complement.
- acc_val  output  1  accumulated sum valid.
- acc_ready  input  1  downstream accepts the sum.
- acc_data  output  2*AW  {acc_re, acc_im}, where AW = 2*DATA_WIDTH+GUARD_BITS. Both halves signed.

Behaviour:
- Reset:
  - rstn low at a clk edge: state=ACCUM, beat counter=0, acc_re=acc_im=0, acc_val=0, acc_data=0.
  - res_ready=1 from the first cycle after reset.
  - sw_rst high gives an identical result. rstn has priority over sw_rst; sw_rst has priority over all other activity.
  - Reset mid-block discards the partial sum and any pending output.
- State ACCUM:
  - res_ready=1, acc_val=0.
  - Transfer occurs when res_val && res_ready at a clk edge.
  - On each transfer: real and imag parts are sign-extended to AW and added to acc_re and acc_im respectively; counter increments.
  - Cycles with res_val=0 leave the state unchanged. Gaps of any length are allowed.
- Transition ACCUM -> OUTPUT:
  - Occurs on the transfer that brings the count to ACC_LEN.
  - The final sum is registered into acc_data on the same edge.
  - acc_val=1 and res_ready=0 from the next cycle. Latency from the last accepted beat to acc_val is 1 cycle.
- State OUTPUT:
  - acc_val=1, res_ready=0. res_val is ignored and res_data is not sampled.
  - acc_data holds stable until accepted.
  - On acc_val && acc_ready: accumulators and counter clear, state returns to ACCUM, acc_val=0 and res_ready=1 next cycle.
  - acc_data keeps its last value after acceptance; its contents are don't-care while acc_val=0.
- Throughput: at most one result per cycle in ACCUM. Each output costs a minimum of 1 idle input cycle.
- res_ready and acc_val are decoded from the state register only, with no combinational path from res_val or acc_ready.
- Arithmetic:
  - Additions wrap modulo 2^AW. No saturation, no overflow flag.
  - Overflow cannot occur when the GUARD_BITS constraint holds.
- Handshake compliance:
  - Upstream may hold res_val high with changing data only across accepted beats.
  - The block never deasserts acc_val before acceptance, except on reset.

Test Plan (DATA_WIDTH=8, ACC_LEN=4, GUARD_BITS=4, AW=20):
- Basic sum: 4 back-to-back beats with real=100, imag=-50 (res_data=0x0064FFCE).
  - acc_val rises 1 cycle after the 4th beat.
  - acc_data=0x00190FFF38 (re=400, im=-200).
  - res_ready=0 while acc_val=1.
- Corner values: 4 beats with real=-32768, imag=32767 (0x80007FFF).
  - acc_data=0xE00001FFFC (re=-131072, im=131068). No wrap.
- Input gaps: beats real=1,2,3,4 and imag=0, with res_val low 3 cycles between beats.
  - acc_data=0x0000A00000.
  - No extra counts during gaps.
- Output backpressure: acc_ready held low 10 cycles after acc_val, with res_val held high (data 0x00010001).
  - acc_val and acc_data stay stable, res_ready stays 0, no beats consumed.
  - After acc_ready=1 for one cycle, 4 new beats yield acc_data=0x0000400004.
- Reset mid-block: 2 beats of 0x00050005, then rstn=0 for one cycle, then 4 beats of 0x00010001.
  - All outputs are 0 during reset; res_ready=1 after it.
  - The sum is 0x0000400004, so the partial sum was discarded.
- Soft reset in OUTPUT: assert sw_rst one cycle while acc_val=1.
  - acc_val=0 and res_ready=1 next cycle.
  - The next 4 beats of 0x00020002 give 0x0000800008.

Source files
------------

// File: rtl/complex_result_accumulator.sv
// Sums ACC_LEN complex multiplier results and presents the sum on a valid/ready output.
// Latency: sum valid 1 cycle after the last accepted beat.
// Backpressure: input is stalled (res_ready=0) while the sum waits for acc_ready.
module complex_result_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_LEN    = 4,
    parameter int GUARD_BITS = 4
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      sw_rst,
    input  logic                                      res_val,
    output logic                                      res_ready,
    input  logic [4*DATA_WIDTH-1:0]                   res_data,
    output logic                                      acc_val,
    input  logic                                      acc_ready,
    output logic [2*(2*DATA_WIDTH+GUARD_BITS)-1:0]    acc_data
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + GUARD_BITS;
    localparam int CW = 8;

    typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] beat_cnt;
    logic [AW-1:0] acc_re;
    logic [AW-1:0] acc_im;
    logic [AW-1:0] sum_re;
    logic [AW-1:0] sum_im;
    logic          xfer;
    logic          last_beat;
    logic          take;
    logic          clr;

    // Handshake outputs come straight from the state register.
    assign res_ready = (state == ST_ACCUM);
    assign acc_val   = (state == ST_OUTPUT);

    assign xfer      = res_val && res_ready;
    assign take      = acc_val && acc_ready;
    assign last_beat = (beat_cnt == CW'(ACC_LEN - 1));
    assign clr       = !rstn || sw_rst;

    assign sum_re = acc_re + {{GUARD_BITS{res_data[4*DATA_WIDTH-1]}}, res_data[4*DATA_WIDTH-1:PW]};
    assign sum_im = acc_im + {{GUARD_BITS{res_data[PW-1]}}, res_data[PW-1:0]};

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:  if (xfer && last_beat) state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (take)              state_nxt = ST_ACCUM;
            default:                          state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            beat_cnt <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            acc_data <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
            acc_re   <= sum_re;
            acc_im   <= sum_im;
            if (last_beat) begin
                acc_data <= {sum_re, sum_im};
            end
        end else if (take) begin
            // acc_data deliberately keeps the delivered sum.
            beat_cnt <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
        end
    end

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Bench for complex_result_accumulator: directed scenarios plus randomized blocks against a sum model.
module tb_complex_result_accumulator;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sw_rst = 1'b0;
    logic        res_val = 1'b0;
    logic [31:0] res_data = '0;
    logic        acc_ready = 1'b0;
    logic        res_ready;
    logic        acc_val;
    logic [39:0] acc_data;

    int tests = 0;
    int fails = 0;

    complex_result_accumulator #(
        .DATA_WIDTH(8),
        .ACC_LEN(4),
        .GUARD_BITS(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sw_rst(sw_rst),
        .res_val(res_val),
        .res_ready(res_ready),
        .res_data(res_data),
        .acc_val(acc_val),
        .acc_ready(acc_ready),
        .acc_data(acc_data)
    );

    always #5 clk = ~clk;

    // Reference: plain integer sums of the signed 16-bit parts, truncated to 20 bits.
    function automatic logic [39:0] model_sum(input logic [31:0] beats[$]);
        int re;
        int im;
        logic [19:0] r20;
        logic [19:0] i20;
        re = 0;
        im = 0;
        foreach (beats[k]) begin
            re += int'($signed(beats[k][31:16]));
            im += int'($signed(beats[k][15:0]));
        end
        r20 = re[19:0];
        i20 = im[19:0];
        return {r20, i20};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beats(input logic [31:0] d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            res_val  = 1'b1;
            res_data = d;
            step();
            res_val = 1'b0;
            for (int g = 0; g < gap && i < n - 1; g++) step();
        end
    endtask

    task automatic accept_out();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        tests++;
        if (acc_val !== 1'b0 || acc_data !== 40'h0) begin
            fails++;
            $display("FAIL reset_outputs acc_val=%b acc_data=%h required 0/0", acc_val, acc_data);
        end
        rstn = 1'b1;
        step();
        tests++;
        if (res_ready !== 1'b1 || acc_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready res_ready=%b acc_val=%b required 1/0", res_ready, acc_val);
        end
    endtask

    task automatic test_basic();
        drive_beats(32'h0064FFCE, 3, 0);
        tests++;
        if (acc_val !== 1'b0) begin
            fails++;
            $display("FAIL basic_early acc_val=%b required 0 after 3 beats", acc_val);
        end
        drive_beats(32'h0064FFCE, 1, 0);
        tests++;
        if (acc_val !== 1'b1 || res_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency acc_val=%b res_ready=%b required 1/0", acc_val, res_ready);
        end
        tests++;
        if (acc_data !== 40'h00190FFF38) begin
            fails++;
            $display("FAIL basic_data got %h required 00190fff38", acc_data);
        end
        accept_out();
        tests++;
        if (acc_val !== 1'b0 || res_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_accept acc_val=%b res_ready=%b required 0/1", acc_val, res_ready);
        end
    endtask

    task automatic test_corner();
        drive_beats(32'h80007FFF, 4, 0);
        tests++;
        if (acc_val !== 1'b1 || acc_data !== 40'hE00001FFFC) begin
            fails++;
            $display("FAIL corner_data acc_val=%b got %h required 1/e00001fffc", acc_val, acc_data);
        end
        accept_out();
    endtask

    task automatic test_gaps();
        for (int i = 1; i <= 4; i++) begin
            res_val  = 1'b1;
            res_data = {16'(i), 16'h0000};
            step();
            res_val = 1'b0;
            if (i < 4) begin
                for (int g = 0; g < 3; g++) step();
                tests++;
                if (acc_val !== 1'b0) begin
                    fails++;
                    $display("FAIL gaps_early beat=%0d acc_val=%b required 0", i, acc_val);
                end
            end
        end
        tests++;
        if (acc_val !== 1'b1 || acc_data !== 40'h0000A00000) begin
            fails++;
            $display("FAIL gaps_data acc_val=%b got %h required 1/0000a00000", acc_val, acc_data);
        end
        accept_out();
    endtask

    task automatic test_backpressure();
        int bad;
        drive_beats(32'h00010001, 4, 0);
        res_val  = 1'b1;
        res_data = 32'h00010001;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (acc_val !== 1'b1 || res_ready !== 1'b0 || acc_data !== 40'h0000400004) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold bad_cycles=%0d required 0 (last acc_val=%b res_ready=%b data=%h)",
                     bad, acc_val, res_ready, acc_data);
        end
        accept_out();
        // res_val is still high: exactly four more beats should complete the next block.
        for (int c = 0; c < 4; c++) step();
        res_val = 1'b0;
        tests++;
        if (acc_val !== 1'b1 || acc_data !== 40'h0000400004) begin
            fails++;
            $display("FAIL bp_next acc_val=%b got %h required 1/0000400004", acc_val, acc_data);
        end
        accept_out();
    endtask

    task automatic test_reset_mid();
        drive_beats(32'h00050005, 2, 0);
        rstn = 1'b0;
        step();
        tests++;
        if (acc_val !== 1'b0 || acc_data !== 40'h0) begin
            fails++;
            $display("FAIL midrst_outputs acc_val=%b acc_data=%h required 0/0", acc_val, acc_data);
        end
        rstn = 1'b1;
        tests++;
        if (res_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready res_ready=%b required 1", res_ready);
        end
        drive_beats(32'h00010001, 4, 0);
        tests++;
        if (acc_val !== 1'b1 || acc_data !== 40'h0000400004) begin
            fails++;
            $display("FAIL midrst_data acc_val=%b got %h required 1/0000400004", acc_val, acc_data);
        end
        accept_out();
    endtask

    task automatic test_soft_reset();
        drive_beats(32'h00050005, 4, 0);
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        tests++;
        if (acc_val !== 1'b0 || res_ready !== 1'b1) begin
            fails++;
            $display("FAIL swrst_state acc_val=%b res_ready=%b required 0/1", acc_val, res_ready);
        end
        drive_beats(32'h00020002, 4, 0);
        tests++;
        if (acc_val !== 1'b1 || acc_data !== 40'h0000800008) begin
            fails++;
            $display("FAIL swrst_data acc_val=%b got %h required 1/0000800008", acc_val, acc_data);
        end
        accept_out();
    endtask

    task automatic test_random();
        logic [31:0] beats[$];
        logic [31:0] d;
        logic [39:0] exp_sum;
        int wait_cyc;
        for (int blk = 0; blk < 25; blk++) begin
            beats = {};
            for (int i = 0; i < 4; i++) begin
                d = $urandom;
                beats.push_back(d);
                drive_beats(d, 1, 0);
                if (i < 3) begin
                    wait_cyc = int'($urandom_range(0, 2));
                    for (int g = 0; g < wait_cyc; g++) step();
                end
            end
            exp_sum = model_sum(beats);
            // Junk offered while the sum is pending must be ignored.
            wait_cyc = int'($urandom_range(0, 3));
            for (int g = 0; g < wait_cyc; g++) begin
                res_val  = 1'b1;
                res_data = $urandom;
                step();
            end
            res_val = 1'b0;
            tests++;
            if (acc_val !== 1'b1 || acc_data !== exp_sum) begin
                fails++;
                $display("FAIL rand_block%0d acc_val=%b got %h required 1/%h", blk, acc_val, acc_data, exp_sum);
            end
            accept_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_soft_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
